// File: rtl/core_pkg.sv
// Shared RV32I core definitions: branch funct3 encodings, PC FSM states, reset PC.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Decodes a branch funct3 into the comparator's unsigned select and
// turns the comparator's eq/lt results into a branch condition.
module branch_cond_eval
  import core_pkg::*;
(
  input  logic       is_branch_i,
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  output logic       cond_o,
  output logic       br_un_o,
  output logic       illegal_o
);

  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = br_eq_i;
      F3_BNE:  cond_o = !br_eq_i;
      F3_BLT:  cond_o = br_lt_i;
      F3_BGE:  cond_o = !br_lt_i;
      F3_BLTU: cond_o = br_lt_i;
      F3_BGEU: cond_o = !br_lt_i;
      // 010/011 are reserved encodings: never taken
      default: illegal_o = is_branch_i;
    endcase
  end

  assign br_un_o = is_branch_i && ((funct3_i == F3_BLTU) || (funct3_i == F3_BGEU));

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC register with branch/JAL/JALR target selection,
// misaligned-target HALT trap and branch performance counters.
module branch_pc_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic             resume,
  output logic             BrUn,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      pc_next,
  output logic             taken,
  output logic             flush,
  output logic             halted,
  output logic             misalign,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  pc_state_t        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  logic        cond;
  logic [31:0] target;
  logic        retire;
  logic        target_misaligned;

  branch_cond_eval u_cond (
    .is_branch_i (is_branch),
    .funct3_i    (funct3),
    .br_eq_i     (BrEq),
    .br_lt_i     (BrLt),
    .cond_o      (cond),
    .br_un_o     (BrUn),
    .illegal_o   (illegal_br)
  );

  // Target select: JALR outranks JAL/branch, which share pc + imm
  always_comb begin
    pc_plus4          = pc_q + 32'd4;
    taken             = (is_branch && cond) || is_jal || is_jalr;
    target            = is_jalr ? ((rs1_data + imm) & ~32'h1) : (pc_q + imm);
    pc_next           = taken ? target : pc_plus4;
    retire            = (state_q == RUN) && inst_valid && !stall;
    target_misaligned = taken && (target[1:0] != 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    br_cnt_d   = br_cnt_q;
    tk_cnt_d   = tk_cnt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (retire) begin
          if (is_branch) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
            if (taken) tk_cnt_d = tk_cnt_q + CNT_W'(1);
          end
          // A misaligned target traps without touching pc
          if (target_misaligned) begin
            state_d    = HALT;
            misalign_d = 1'b1;
          end else begin
            pc_d    = pc_next;
            flush_d = taken;
          end
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          pc_d    = pc_plus4;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      br_cnt_q   <= '0;
      tk_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      br_cnt_q   <= br_cnt_d;
      tk_cnt_q   <= tk_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign flush        = flush_q;
  assign misalign     = misalign_q;
  assign halted       = (state_q == HALT);
  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = tk_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Table-driven bench for branch_pc_unit with a post-edge scoreboard queue.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        inst_valid, stall, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_data;
  logic        BrEq, BrLt, resume;
  logic        BrUn, taken, flush, halted, misalign, illegal_br;
  logic [31:0] pc, pc_plus4, pc_next;
  logic [3:0]  br_cnt, br_taken_cnt;

  branch_pc_unit #(.RESET_PC(32'h0000_0100), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .imm(imm), .rs1_data(rs1_data), .BrEq(BrEq), .BrLt(BrLt), .resume(resume),
    .BrUn(BrUn), .pc(pc), .pc_plus4(pc_plus4), .pc_next(pc_next), .taken(taken),
    .flush(flush), .halted(halted), .misalign(misalign), .illegal_br(illegal_br),
    .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, st, br, jal, jalr;
    logic [2:0] f3;
    logic [31:0] imm, rs1;
    logic eq, lt, res;
    logic e_brun, e_tk, e_ill;
    logic [31:0] e_pcn;
    logic [31:0] e_pc;
    logic e_fl, e_mis, e_hlt;
    logic [3:0] e_bc, e_tc;
  } vec_t;

  typedef struct {
    int idx;
    logic [31:0] pc;
    logic fl, mis, hlt;
    logic [3:0] bc, tc;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];
  int    n_applied = 0;
  int    n_fail = 0;

  function automatic void add(input logic v, st, br, jal, jalr, input logic [2:0] f3,
                              input logic [31:0] im, rs, input logic eq, lt, res,
                              input logic brun, tk, ill, input logic [31:0] pcn,
                              input logic [31:0] p, input logic fl, mis, hlt,
                              input logic [3:0] bc, tc);
    vec_t x;
    x.v = v; x.st = st; x.br = br; x.jal = jal; x.jalr = jalr; x.f3 = f3;
    x.imm = im; x.rs1 = rs; x.eq = eq; x.lt = lt; x.res = res;
    x.e_brun = brun; x.e_tk = tk; x.e_ill = ill; x.e_pcn = pcn;
    x.e_pc = p; x.e_fl = fl; x.e_mis = mis; x.e_hlt = hlt; x.e_bc = bc; x.e_tc = tc;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    post_t p;
    inst_valid = 0; stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 0; imm = 0; rs1_data = 0; BrEq = 0; BrLt = 0; resume = 0;
    rst_n = 1'b0;

    //  v st br jal jalr f3  imm            rs1       eq lt res | brun tk ill pc_next      | pc           fl mis hlt bc tc
    add(1,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_0104, 32'h0000_0100, 0,0,0, 4'd0,4'd0); // BOOT: no retire
    add(1,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_0104, 32'h0000_0104, 0,0,0, 4'd0,4'd0);
    add(1,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_0108, 32'h0000_0108, 0,0,0, 4'd0,4'd0);
    add(1,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_010C, 32'h0000_010C, 0,0,0, 4'd0,4'd0);
    add(1,0, 0,1,0, 3'd0, 32'h0000_00F4,  32'h0,    0,0,0,  0,1,0, 32'h0000_0200, 32'h0000_0200, 1,0,0, 4'd0,4'd0); // JAL
    add(1,0, 1,0,0, 3'd7, 32'hFFFF_FFF0,  32'h0,    0,0,0,  1,1,0, 32'h0000_01F0, 32'h0000_01F0, 1,0,0, 4'd1,4'd1); // BGEU taken
    add(1,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_01F4, 32'h0000_01F4, 0,0,0, 4'd1,4'd1);
    add(1,0, 0,1,0, 3'd0, 32'h0000_010C,  32'h0,    0,0,0,  0,1,0, 32'h0000_0300, 32'h0000_0300, 1,0,0, 4'd1,4'd1);
    add(1,1, 1,0,0, 3'd1, 32'h0000_0040,  32'h0,    1,0,0,  0,0,0, 32'h0000_0304, 32'h0000_0300, 0,0,0, 4'd1,4'd1); // BNE stalled
    add(1,1, 1,0,0, 3'd1, 32'h0000_0040,  32'h0,    1,0,0,  0,0,0, 32'h0000_0304, 32'h0000_0300, 0,0,0, 4'd1,4'd1);
    add(1,0, 1,0,0, 3'd1, 32'h0000_0040,  32'h0,    1,0,0,  0,0,0, 32'h0000_0304, 32'h0000_0304, 0,0,0, 4'd2,4'd1);
    add(1,0, 0,0,1, 3'd0, 32'h0000_0002,  32'h1003, 0,0,0,  0,1,0, 32'h0000_1004, 32'h0000_1004, 1,0,0, 4'd2,4'd1); // JALR bit0 cleared
    add(1,0, 0,0,1, 3'd0, 32'h0000_0002,  32'h1000, 0,0,0,  0,1,0, 32'h0000_1002, 32'h0000_1004, 0,1,1, 4'd2,4'd1); // misaligned -> HALT
    add(1,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_1008, 32'h0000_1004, 0,0,1, 4'd2,4'd1);
    add(0,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,1,  0,0,0, 32'h0000_1008, 32'h0000_1008, 0,0,0, 4'd2,4'd1); // resume
    add(0,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,1,  0,0,0, 32'h0000_100C, 32'h0000_1008, 0,0,0, 4'd2,4'd1); // resume ignored in RUN
    add(1,0, 1,0,0, 3'd2, 32'h0000_0040,  32'h0,    1,1,0,  0,0,1, 32'h0000_100C, 32'h0000_100C, 0,0,0, 4'd3,4'd1); // illegal funct3
    for (int k = 0; k < 16; k++) begin
      logic [31:0] pk;
      pk = 32'h0000_100C + 32'(8 * k);
      add(1,0, 1,0,0, 3'd0, 32'h0000_0008, 32'h0, 1,0,0, 0,1,0, pk + 32'd8, pk + 32'd8, 1,0,0,
          4'(3 + k + 1), 4'(1 + k + 1));
    end
    add(1,0, 1,0,0, 3'd4, 32'hFFFF_FFF8,  32'h0,    0,1,0,  0,1,0, 32'h0000_1084, 32'h0000_1084, 1,0,0, 4'd4,4'd2); // BLT taken
    add(1,0, 1,0,0, 3'd5, 32'h0,          32'h0,    0,1,0,  0,0,0, 32'h0000_1088, 32'h0000_1088, 0,0,0, 4'd5,4'd2); // BGE not taken
    add(1,0, 1,0,0, 3'd6, 32'h0000_0010,  32'h0,    0,0,0,  1,0,0, 32'h0000_108C, 32'h0000_108C, 0,0,0, 4'd6,4'd2); // BLTU not taken
    add(1,0, 1,0,0, 3'd0, 32'h0000_0010,  32'h0,    0,0,0,  0,0,0, 32'h0000_1090, 32'h0000_1090, 0,0,0, 4'd7,4'd2); // BEQ not taken
    add(1,0, 0,1,0, 3'd0, 32'hFFFF_EF6C,  32'h0,    0,0,0,  0,1,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0,0, 4'd7,4'd2);
    add(1,0, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_0000, 32'h0000_0000, 0,0,0, 4'd7,4'd2); // PC wrap
    add(1,0, 1,0,0, 3'd0, 32'h0000_0006,  32'h0,    1,0,0,  0,1,0, 32'h0000_0006, 32'h0000_0000, 0,1,1, 4'd8,4'd3); // misaligned branch still counted
    add(1,1, 0,0,0, 3'd0, 32'h0,          32'h0,    0,0,0,  0,0,0, 32'h0000_0004, 32'h0000_0000, 0,0,1, 4'd8,4'd3);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", -1, pc, 32'h0000_0100);
    chk("rst_flush", -1, 32'(flush), 32'd0);
    chk("rst_misalign", -1, 32'(misalign), 32'd0);
    chk("rst_halted", -1, 32'(halted), 32'd0);
    chk("rst_br_cnt", -1, 32'(br_cnt), 32'd0);
    chk("rst_br_taken_cnt", -1, 32'(br_taken_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      inst_valid = vecs[i].v;   stall   = vecs[i].st;  is_branch = vecs[i].br;
      is_jal     = vecs[i].jal; is_jalr = vecs[i].jalr; funct3   = vecs[i].f3;
      imm        = vecs[i].imm; rs1_data = vecs[i].rs1;
      BrEq = vecs[i].eq; BrLt = vecs[i].lt; resume = vecs[i].res;
      #1;
      chk("BrUn", i, 32'(BrUn), 32'(vecs[i].e_brun));
      chk("taken", i, 32'(taken), 32'(vecs[i].e_tk));
      chk("illegal_br", i, 32'(illegal_br), 32'(vecs[i].e_ill));
      chk("pc_next", i, pc_next, vecs[i].e_pcn);
      p.idx = i; p.pc = vecs[i].e_pc; p.fl = vecs[i].e_fl; p.mis = vecs[i].e_mis;
      p.hlt = vecs[i].e_hlt; p.bc = vecs[i].e_bc; p.tc = vecs[i].e_tc;
      sb.push_back(p);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_applied++; n_fail++;
        $display("FAIL scoreboard (vec %0d): got empty queue, expected an entry", i);
      end else begin
        p = sb.pop_front();
        chk("pc", p.idx, pc, p.pc);
        chk("flush", p.idx, 32'(flush), 32'(p.fl));
        chk("misalign", p.idx, 32'(misalign), 32'(p.mis));
        chk("halted", p.idx, 32'(halted), 32'(p.hlt));
        chk("br_cnt", p.idx, 32'(br_cnt), 32'(p.bc));
        chk("br_taken_cnt", p.idx, 32'(br_taken_cnt), 32'(p.tc));
      end
      @(negedge clk);
    end

    // Asynchronous reset while halted and stalled, away from any clock edge
    inst_valid = 1; stall = 1; is_branch = 0; is_jal = 0; is_jalr = 0; resume = 0;
    imm = 0; funct3 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", -2, pc, 32'h0000_0100);
    chk("async_halted", -2, 32'(halted), 32'd0);
    chk("async_br_cnt", -2, 32'(br_cnt), 32'd0);
    chk("async_br_taken_cnt", -2, 32'(br_taken_cnt), 32'd0);
    chk("async_misalign", -2, 32'(misalign), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; stall = 0;
    @(posedge clk);
    #1;
    chk("boot_pc", -3, pc, 32'h0000_0100);
    chk("boot_halted", -3, 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    chk("run_pc", -4, pc, 32'h0000_0104);
    chk("run_flush", -4, 32'(flush), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumer end of the branch comparator interface: drives BrUn from the branch funct3 and turns BrEq/BrLt into a taken/not-taken decision.
- Owns the architectural PC register, computes branch/JAL/JALR targets and traps misaligned targets into a HALT state.
- Keeps branch performance counters.
- Sits between decode/register-file read and instruction fetch in the RV32I core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  current instruction is valid and may retire
- stall  in  1  hold PC; the instruction does not retire this cycle
- is_branch  in  1  instruction is a conditional branch (B-type)
- is_jal  in  1  instruction is JAL
- is_jalr  in  1  instruction is JALR
- funct3  in  3  branch funct3 field
- imm  in  32  sign-extended immediate
- rs1_data  in  32  rs1 value, used for JALR
- BrEq  in  1  equality result from the comparator
- BrLt  in  1  less-than result from the comparator
- resume  in  1  single-cycle pulse that exits HALT
- BrUn  out  1  unsigned-compare select to the comparator
- pc  out  32  current PC (registered)
- pc_plus4  out  32  pc + 4
- pc_next  out  32  selected next PC (combinational)
- taken  out  1  control transfer taken (combinational)
- flush  out  1  registered; 1 for the cycle after a retired taken transfer
- halted  out  1  FSM is in HALT
- misalign  out  1  registered; pulses when entering HALT
- illegal_br  out  1  combinational; is_branch with funct3 = 010 or 011
- br_cnt  out  CNT_W  retired conditional branches
- br_taken_cnt  out  CNT_W  retired taken conditional branches

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; flush=0; misalign=0; both counters=0; state=BOOT.
  - All registered outputs take reset values immediately, including mid-instruction.
- BrUn is combinational: 1 iff is_branch and funct3 is 110 (BLTU) or 111 (BGEU); otherwise 0.
- Branch condition by funct3:
  - 000 BEQ = BrEq; 001 BNE = !BrEq.
  - 100 BLT = BrLt; 101 BGE = !BrLt.
  - 110 BLTU = BrLt; 111 BGEU = !BrLt.
  - 010/011 = not taken, and illegal_br=1.
- taken = (is_branch & cond) | is_jal | is_jalr. If more than one is_* is high, priority is jalr > jal > branch.
- Target, all arithmetic mod 2^32 with no overflow flag:
  - branch/JAL: pc + imm.
  - JALR: (rs1_data + imm) & ~32'h1.
- pc_next = taken ? target : pc_plus4.
- Retire condition: retire = (state==RUN) & inst_valid & !stall.
- FSM states:
  - BOOT: one cycle after reset release. pc held, no retire. Goes to RUN unconditionally.
  - RUN: on retire, if taken and target[1:0] != 00, go to HALT. In that case pc is NOT updated, misalign=1 for one cycle, and counters still count the branch. Otherwise on retire, pc <= pc_next.
  - HALT: pc frozen, halted=1, inst_valid ignored. On resume: go to RUN and pc <= pc_plus4 (the faulting instruction is skipped).
- resume while not in HALT: ignored.
- stall=1: pc, counters and flush are unchanged (flush <= 0). stall has priority over inst_valid.
- Latency: pc_next is visible in pc one clock after retire. flush asserts for exactly one cycle after a retired, aligned, taken transfer.
- Counters on retire & is_branch:
  - br_cnt += 1.
  - br_taken_cnt += 1 if taken.
  - Illegal funct3 counts in br_cnt only.
  - Both wrap from all-ones to 0.
- Non-branch instructions (taken=0): pc += 4 on retire. PC wraps 32'hFFFF_FFFC -> 0.

Decomposition:
- Shared package core_pkg:
  - funct3 localparams F3_BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t.
  - RESET_PC default.
- One natural sub-module: branch_cond_eval, the combinational funct3/BrEq/BrLt -> cond, BrUn, illegal_br. It is reusable by a future pipelined core.

Test Plan:
- Reset release, RESET_PC=0x100, no inst_valid -> pc=0x100 through BOOT. Then 3 retires of non-branches -> pc=0x104, 0x108, 0x10C; flush=0 throughout.
- pc=0x200, BGEU funct3=111, BrLt=0, imm=-16 -> BrUn=1, taken=1, pc=0x1F0 next cycle, flush=1 for one cycle, br_cnt=1, br_taken_cnt=1.
- pc=0x300, BNE, BrEq=1 -> taken=0, BrUn=0, pc=0x304. Same instruction with stall=1 for 2 cycles -> pc stays 0x300 and counters unchanged until stall drops.
- JALR with rs1_data=0x1003, imm=2 -> target 0x1004 (bit0 cleared), aligned, pc=0x1004. Then JALR with rs1_data=0x1000, imm=2 -> target 0x1002: HALT, misalign pulse, pc unchanged at 0x1004. resume -> pc=0x1008, state RUN.
- br_taken_cnt preset near wrap via 2^CNT_W retires (or CNT_W=4: 16 taken BEQs) -> counter returns to 0. An illegal funct3=010 retire increments br_cnt only, with illegal_br=1.
- rst_n asserted mid-stall while in HALT -> pc=RESET_PC, halted=0, counters=0 immediately (asynchronous). Then BOOT for one cycle, then RUN.
